alu_arbiter: RTL

- Shares one ALU_TOP instance between two requesters (port 0, port 1) using valid/ready request and response handshakes.
- Round-robin arbitration, one operation in flight at a time.
- Drives ALU_TOP operands and function code, waits the ALU's registered latency, then merges the class-specific ALU outputs into one result word returned to the granted requester.
- Sits between the command sources (sequencer/CPU datapath) and ALU_TOP.

---
 rtl/alu_pkg.sv | 65 ++++++
 rtl/alu_result_mux.sv | 60 ++++++
 rtl/alu_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU function codes, operation class decode and the
//                arbiter FSM state type for ALU front-end blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU_TOP function codes
  localparam logic [3:0] FUN_ADD    = 4'h0;
  localparam logic [3:0] FUN_SUB    = 4'h1;
  localparam logic [3:0] FUN_MUL    = 4'h2;
  localparam logic [3:0] FUN_DIV    = 4'h3;
  localparam logic [3:0] FUN_AND    = 4'h4;
  localparam logic [3:0] FUN_OR     = 4'h5;
  localparam logic [3:0] FUN_NAND   = 4'h6;
  localparam logic [3:0] FUN_NOR    = 4'h7;
  localparam logic [3:0] FUN_NOP    = 4'h8;
  localparam logic [3:0] FUN_CMP_EQ = 4'h9;
  localparam logic [3:0] FUN_CMP_GT = 4'hA;
  localparam logic [3:0] FUN_CMP_LT = 4'hB;
  localparam logic [3:0] FUN_SHR_A  = 4'hC;
  localparam logic [3:0] FUN_SHL_A  = 4'hD;
  localparam logic [3:0] FUN_SHR_B  = 4'hE;
  localparam logic [3:0] FUN_SHL_B  = 4'hF;

  // Latency counter width; covers LATENCY values 1..7
  localparam int CNT_W = 3;

  // Operation class of a function code
  typedef enum logic [2:0] {
    CLS_ARITH = 3'd0,
    CLS_LOGIC = 3'd1,
    CLS_NOP   = 3'd2,
    CLS_CMP   = 3'd3,
    CLS_SHIFT = 3'd4
  } fun_class_e;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Map a 4-bit function code onto its output class
  function automatic fun_class_e fun_class(input logic [3:0] fun);
    fun_class_e cls;
    if (fun < 4'h4) begin
      cls = CLS_ARITH;
    end else if (fun < 4'h8) begin
      cls = CLS_LOGIC;
    end else if (fun == FUN_NOP) begin
      cls = CLS_NOP;
    end else if (fun < 4'hC) begin
      cls = CLS_CMP;
    end else begin
      cls = CLS_SHIFT;
    end
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_mux.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_mux
//  Description : Combinational merge of the class-specific ALU_TOP outputs
//                and flags into one 2*WIDTH result word plus carry and flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_result_mux
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]         fun,
  input  logic [2*WIDTH-1:0] arith_res,
  input  logic [WIDTH-1:0]   logic_res,
  input  logic [WIDTH-1:0]   cmp_res,
  input  logic [WIDTH:0]     shift_res,
  input  logic               carry_in,
  input  logic               aflag,
  input  logic               lflag,
  input  logic               cflag,
  input  logic               sflag,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_out,
  output logic               flag
);

  // Select the output class of the executed function; carry only for arith
  always_comb begin
    result    = '0;
    carry_out = 1'b0;
    flag      = 1'b0;
    case (fun_class(fun))
      CLS_ARITH: begin
        result    = arith_res;
        carry_out = carry_in;
        flag      = aflag;
      end
      CLS_LOGIC: begin
        result = {{WIDTH{1'b0}}, logic_res};
        flag   = lflag;
      end
      CLS_CMP: begin
        result = {{WIDTH{1'b0}}, cmp_res};
        flag   = cflag;
      end
      CLS_SHIFT: begin
        result = {{(WIDTH-1){1'b0}}, shift_res};
        flag   = sflag;
      end
      default: begin
        result    = '0;
        carry_out = 1'b0;
        flag      = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin sharing of one external ALU_TOP between two
//                valid/ready requesters, one operation in flight at a time.
//                Operands are registered at accept, the ALU latency is timed
//                with a down-counter and the merged result is held until the
//                granted requester consumes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  // request side
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  input  logic [7:0]           req_fun,
  // response side
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_flag,
  output logic                 busy,
  // ALU_TOP interface
  output logic                 ALU_RSTN,
  output logic [WIDTH-1:0]     ALU_A,
  output logic [WIDTH-1:0]     ALU_B,
  output logic [3:0]           ALU_FUN,
  input  logic [2*WIDTH-1:0]   ALU_ARITH,
  input  logic [WIDTH-1:0]     ALU_LOGIC,
  input  logic [WIDTH-1:0]     ALU_CMP,
  input  logic [WIDTH:0]       ALU_SHIFT,
  input  logic                 ALU_CARRY,
  input  logic                 ALU_AFLAG,
  input  logic                 ALU_LFLAG,
  input  logic                 ALU_CFLAG,
  input  logic                 ALU_SFLAG
);

  arb_state_e         r_state;
  arb_state_e         w_next_state;
  logic               r_ptr;        // round-robin pointer: favoured requester
  logic               r_gnt;        // requester owning the in-flight operation
  logic [CNT_W-1:0]   r_cnt;        // remaining ALU latency cycles
  logic               w_grant;
  logic               w_accept;
  logic               w_wait_done;
  logic               w_rsp_hs;
  logic [2*WIDTH-1:0] w_mux_result;
  logic               w_mux_carry;
  logic               w_mux_flag;

  // ALU_TOP has an active-low reset
  assign ALU_RSTN = ~RST;

  // Pointer requester wins when valid; otherwise the other one if valid.
  // With no valid request the grant rests on the pointer.
  assign w_grant = req_valid[r_ptr]  ? r_ptr  :
                   req_valid[~r_ptr] ? ~r_ptr : r_ptr;

  assign w_accept    = (r_state == ST_IDLE) && req_valid[w_grant];
  assign w_wait_done = (r_state == ST_WAIT) && (r_cnt == '0);
  assign w_rsp_hs    = (r_state == ST_RESP) && rsp_ready[r_gnt];

  // Merge the ALU outputs according to the function currently driven
  alu_result_mux #(
    .WIDTH (WIDTH)
  ) u_result_mux (
    .fun       (ALU_FUN),
    .arith_res (ALU_ARITH),
    .logic_res (ALU_LOGIC),
    .cmp_res   (ALU_CMP),
    .shift_res (ALU_SHIFT),
    .carry_in  (ALU_CARRY),
    .aflag     (ALU_AFLAG),
    .lflag     (ALU_LFLAG),
    .cflag     (ALU_CFLAG),
    .sflag     (ALU_SFLAG),
    .result    (w_mux_result),
    .carry_out (w_mux_carry),
    .flag      (w_mux_flag)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic: accept -> wait out latency -> hold response
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)    w_next_state = ST_WAIT;
      ST_WAIT: if (w_wait_done) w_next_state = ST_RESP;
      ST_RESP: if (w_rsp_hs)    w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only for the grant in IDLE, valid only for owner in RESP
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: req_ready[w_grant] = 1'b1;
      ST_RESP: rsp_valid[r_gnt]   = 1'b1;
      default: begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
      end
    endcase
  end

  // Datapath: operand capture, latency count, result capture, pointer update
  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_A      <= '0;
      ALU_B      <= '0;
      ALU_FUN    <= FUN_NOP;
      r_ptr      <= 1'b0;
      r_gnt      <= 1'b0;
      r_cnt      <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_flag   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            ALU_A   <= w_grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            ALU_B   <= w_grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
            ALU_FUN <= w_grant ? req_fun[7:4]           : req_fun[3:0];
            r_gnt   <= w_grant;
            r_cnt   <= CNT_W'(LATENCY);
          end else begin
            ALU_FUN <= FUN_NOP;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            rsp_result <= w_mux_result;
            rsp_carry  <= w_mux_carry;
            rsp_flag   <= w_mux_flag;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_ptr   <= ~r_gnt;
            ALU_FUN <= FUN_NOP;
          end
        end
        default: begin
          ALU_FUN <= FUN_NOP;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
